// File: rtl/pc_redirect_unit.sv
// Program counter and fetch-redirect unit: selects the next PC from trap, mret,
// EX control transfers or sequential fetch, and flushes IF/ID after every redirect.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        ex_valid_in,
    input  logic [4:0]  opcode_6_2_in,
    input  logic        branch_taken_in,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic        stall_in,
    input  logic        imem_ready_in,
    output logic        imem_req_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        flush_o,
    output logic        misaligned_o,
    output logic [31:0] misaligned_addr_o,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [2:0]  flush_cnt;

    logic [31:0] pc_rel_target;
    logic [31:0] jalr_target;
    logic [31:0] ex_target;
    logic        ex_transfer;
    logic        ex_misaligned;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mis_detect;
    logic        advance;

    assign pc_rel_target = ex_pc_in + imm_in;
    assign jalr_target   = (rs1_in + imm_in) & 32'hFFFF_FFFE;
    assign pc_plus4_o    = pc_o + 32'd4;
    assign state_dbg_o   = state;

    // EX transfers only count in RUN; during FLUSH they belong to the wrong path.
    always_comb begin
        ex_transfer = 1'b0;
        ex_target   = pc_rel_target;
        if (ex_valid_in && (state == ST_RUN)) begin
            case (opcode_6_2_in)
                OP_BRANCH: ex_transfer = branch_taken_in;
                OP_JAL:    ex_transfer = 1'b1;
                OP_JALR: begin
                    ex_transfer = 1'b1;
                    ex_target   = jalr_target;
                end
                default:   ex_transfer = 1'b0;
            endcase
        end
    end

    assign ex_misaligned = ex_transfer && (ex_target[1:0] != 2'b00);

    // Fixed priority: trap, then mret, then an aligned EX transfer.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = ex_target;
        if (trap_taken_in) begin
            redirect    = 1'b1;
            redirect_pc = trap_vector_in;
        end else if (mret_in) begin
            redirect    = 1'b1;
            redirect_pc = epc_in;
        end else if (ex_transfer && !ex_misaligned) begin
            redirect    = 1'b1;
            redirect_pc = ex_target;
        end
    end

    assign mis_detect = !trap_taken_in && !mret_in && ex_misaligned;
    assign advance    = imem_req_o && imem_ready_in && !stall_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= ST_BOOT;
            pc_o              <= RESET_VECTOR;
            flush_cnt         <= 3'd0;
            imem_req_o        <= 1'b0;
            flush_o           <= 1'b0;
            misaligned_o      <= 1'b0;
            misaligned_addr_o <= 32'd0;
        end else begin
            misaligned_o <= mis_detect;
            if (mis_detect) begin
                misaligned_addr_o <= ex_target;
            end

            if (redirect) begin
                // A redirect wins over stall and memory backpressure.
                pc_o       <= redirect_pc;
                state      <= ST_FLUSH;
                flush_cnt  <= FLUSH_LOAD;
                imem_req_o <= 1'b1;
                flush_o    <= 1'b1;
            end else begin
                if (advance) begin
                    pc_o <= pc_o + 32'd4;
                end
                case (state)
                    ST_BOOT: begin
                        state      <= ST_RUN;
                        imem_req_o <= 1'b1;
                        flush_o    <= 1'b0;
                    end
                    ST_RUN: begin
                        imem_req_o <= 1'b1;
                        flush_o    <= 1'b0;
                    end
                    ST_FLUSH: begin
                        imem_req_o <= 1'b1;
                        if (flush_cnt == 3'd0) begin
                            state   <= ST_RUN;
                            flush_o <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                            flush_o   <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= ST_BOOT;
                        imem_req_o <= 1'b0;
                        flush_o    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the PC rules.
module tb_pc_redirect_unit;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [4:0]  opc;
    logic        br_taken;
    logic [31:0] ex_pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        trap;
    logic [31:0] trap_vec;
    logic        mret;
    logic [31:0] epc;
    logic        stall;
    logic        ready;
    logic        imem_req_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        flush_o;
    logic        misaligned_o;
    logic [31:0] misaligned_addr_o;
    logic [1:0]  state_dbg_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    // Behavioural model: PC value, boot flag, remaining flush cycles, misaligned report.
    logic [31:0] m_pc;
    logic        m_boot;
    int          m_fl;
    logic        m_mis;
    logic [31:0] m_mis_addr;

    pc_redirect_unit #(.RESET_VECTOR(RV), .FLUSH_CYCLES(FC)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .ex_valid_in(ex_valid), .opcode_6_2_in(opc),
        .branch_taken_in(br_taken), .ex_pc_in(ex_pc), .imm_in(imm), .rs1_in(rs1),
        .trap_taken_in(trap), .trap_vector_in(trap_vec), .mret_in(mret), .epc_in(epc),
        .stall_in(stall), .imem_ready_in(ready), .imem_req_o(imem_req_o), .pc_o(pc_o),
        .pc_plus4_o(pc_plus4_o), .flush_o(flush_o), .misaligned_o(misaligned_o),
        .misaligned_addr_o(misaligned_addr_o), .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = RV; m_boot = 1'b1; m_fl = 0; m_mis = 1'b0; m_mis_addr = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        logic        take;
        logic        redir;
        logic        mis_n;
        logic        req;
        tgt = 32'd0; take = 1'b0; redir = 1'b0; mis_n = 1'b0;
        req = !m_boot;
        if (trap) begin
            redir = 1'b1; tgt = trap_vec;
        end else if (mret) begin
            redir = 1'b1; tgt = epc;
        end else if (ex_valid && !m_boot && m_fl == 0) begin
            if (opc == 5'b11000) begin take = br_taken; tgt = ex_pc + imm; end
            else if (opc == 5'b11011) begin take = 1'b1; tgt = ex_pc + imm; end
            else if (opc == 5'b11001) begin take = 1'b1; tgt = (rs1 + imm) / 2 * 2; end
            if (take) begin
                if (tgt % 4 != 0) mis_n = 1'b1;
                else redir = 1'b1;
            end
        end
        if (redir) begin
            m_pc = tgt; m_fl = FC; m_boot = 1'b0;
        end else begin
            if (req && ready && !stall) m_pc = m_pc + 32'd4;
            if (m_boot) m_boot = 1'b0;
            else if (m_fl > 0) m_fl = m_fl - 1;
        end
        m_mis = mis_n;
        if (mis_n) m_mis_addr = tgt;
    endtask

    task automatic idle();
        ex_valid = 0; opc = 5'b00100; br_taken = 0; ex_pc = 0; imm = 0; rs1 = 0;
        trap = 0; trap_vec = 0; mret = 0; epc = 0; stall = 0; ready = 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pc_o !== RV || imem_req_o !== 1'b0 || flush_o !== 1'b0 ||
            misaligned_o !== 1'b0 || misaligned_addr_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_state pc=%h req=%b flush=%b mis=%b addr=%h want pc=%h zeros",
                     pc_o, imem_req_o, flush_o, misaligned_o, misaligned_addr_o, RV);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (imem_req_o !== 1'b0) begin
            bad++; $display("FAIL boot_req got=%b want=0", imem_req_o);
        end
        exp_q.push_back(RV);
        exp_q.push_back(RV + 32'd4);
        exp_q.push_back(RV + 32'd8);
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            cycle();
            e = exp_q.pop_front();
            total++;
            if (pc_o !== e || imem_req_o !== 1'b1 || pc_plus4_o !== e + 32'd4) begin
                bad++;
                $display("FAIL seq_pc got=%h req=%b p4=%h want=%h req=1", pc_o, imem_req_o, pc_plus4_o, e);
            end
        end
    endtask

    task automatic test_branch_flush();
        idle();
        ex_valid = 1; opc = 5'b11000; br_taken = 1; ex_pc = 32'h200; imm = 32'h40;
        cycle();
        idle();
        total++;
        if (pc_o !== 32'h240 || flush_o !== 1'b1) begin
            bad++; $display("FAIL branch_redirect pc=%h flush=%b want 240 1", pc_o, flush_o);
        end
        ex_valid = 1; opc = 5'b11011; ex_pc = 32'h300; imm = 32'h10;
        cycle();
        idle();
        total++;
        if (pc_o !== 32'h244 || flush_o !== 1'b1 || pc_o !== m_pc) begin
            bad++; $display("FAIL jal_in_flush pc=%h flush=%b want 244 1", pc_o, flush_o);
        end
        cycle();
        total++;
        if (pc_o !== 32'h248 || flush_o !== 1'b0) begin
            bad++; $display("FAIL flush_end pc=%h flush=%b want 248 0", pc_o, flush_o);
        end
    endtask

    task automatic test_jalr_misaligned();
        logic [31:0] p;
        idle();
        p = pc_o;
        ex_valid = 1; opc = 5'b11001; rs1 = 32'h1003; imm = 32'h4;
        cycle();
        idle();
        total++;
        if (misaligned_o !== 1'b1 || misaligned_addr_o !== 32'h1006 || pc_o !== p + 32'd4 ||
            flush_o !== 1'b0) begin
            bad++;
            $display("FAIL jalr_mis mis=%b addr=%h pc=%h flush=%b want 1 1006 %h 0",
                     misaligned_o, misaligned_addr_o, pc_o, flush_o, p + 32'd4);
        end
        cycle();
        total++;
        if (misaligned_o !== 1'b0 || pc_o !== p + 32'd8) begin
            bad++; $display("FAIL jalr_mis_pulse mis=%b pc=%h want 0 %h", misaligned_o, pc_o, p + 32'd8);
        end
    endtask

    task automatic test_priority();
        idle();
        trap = 1; trap_vec = 32'h80; mret = 1; epc = 32'h500;
        ex_valid = 1; opc = 5'b11000; br_taken = 1; ex_pc = 32'h600; imm = 32'h8;
        cycle();
        idle();
        total++;
        if (pc_o !== 32'h80 || flush_o !== 1'b1) begin
            bad++; $display("FAIL trap_priority pc=%h flush=%b want 80 1", pc_o, flush_o);
        end
        repeat (3) cycle();
        total++;
        if (pc_o !== 32'h8C || flush_o !== 1'b0) begin
            bad++; $display("FAIL after_trap pc=%h flush=%b want 8c 0", pc_o, flush_o);
        end
    endtask

    task automatic test_stall();
        logic [31:0] p;
        idle();
        p = pc_o;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (pc_o !== p) begin
                bad++; $display("FAIL stall_hold[%0d] pc=%h want=%h", i, pc_o, p);
            end
        end
        ex_valid = 1; opc = 5'b11000; br_taken = 1; ex_pc = 32'h700; imm = 32'h20;
        cycle();
        idle();
        total++;
        if (pc_o !== 32'h720 || flush_o !== 1'b1) begin
            bad++; $display("FAIL stall_redirect pc=%h flush=%b want 720 1", pc_o, flush_o);
        end
    endtask

    task automatic test_wrap_and_reset();
        idle();
        repeat (3) cycle();
        trap = 1; trap_vec = 32'hFFFF_FFFC;
        cycle();
        idle();
        total++;
        if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
            bad++; $display("FAIL wrap_setup pc=%h p4=%h want fffffffc 0", pc_o, pc_plus4_o);
        end
        cycle();
        total++;
        if (pc_o !== 32'h0 || flush_o !== 1'b1) begin
            bad++; $display("FAIL wrap pc=%h flush=%b want 0 1", pc_o, flush_o);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (flush_o !== 1'b0 || pc_o !== RV || imem_req_o !== 1'b0) begin
            bad++; $display("FAIL async_reset flush=%b pc=%h req=%b want 0 %h 0", flush_o, pc_o, imem_req_o, RV);
        end
        #3 rst_n = 1'b1;
        cycle();
        total++;
        if (pc_o !== RV || imem_req_o !== 1'b1 || flush_o !== 1'b0) begin
            bad++; $display("FAIL reboot pc=%h req=%b flush=%b want %h 1 0", pc_o, imem_req_o, flush_o, RV);
        end
    endtask

    task automatic test_random();
        logic [4:0] ops [4];
        ops[0] = 5'b11000; ops[1] = 5'b11011; ops[2] = 5'b11001; ops[3] = 5'b00100;
        for (int i = 0; i < 400; i++) begin
            trap     = ($urandom_range(0, 15) == 0);
            trap_vec = $urandom() & 32'hFFFF_FFFC;
            mret     = ($urandom_range(0, 15) == 0);
            epc      = $urandom() & 32'hFFFF_FFFC;
            ex_valid = $urandom_range(0, 1);
            opc      = ops[$urandom_range(0, 3)];
            br_taken = $urandom_range(0, 1);
            ex_pc    = $urandom() & 32'hFFFF_FFFC;
            imm      = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
            rs1      = $urandom();
            if ($urandom_range(0, 1) == 0) rs1 = rs1 & 32'hFFFF_FFFC;
            stall    = ($urandom_range(0, 3) == 0);
            ready    = ($urandom_range(0, 3) != 0);
            cycle();
            total++;
            if (pc_o !== m_pc || pc_plus4_o !== m_pc + 32'd4 || imem_req_o !== !m_boot ||
                flush_o !== (m_fl > 0) || misaligned_o !== m_mis || misaligned_addr_o !== m_mis_addr) begin
                bad++;
                $display("FAIL random[%0d] pc=%h req=%b flush=%b mis=%b addr=%h want pc=%h req=%b flush=%b mis=%b addr=%h",
                         i, pc_o, imem_req_o, flush_o, misaligned_o, misaligned_addr_o,
                         m_pc, !m_boot, (m_fl > 0), m_mis, m_mis_addr);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_branch_flush();
        test_jalr_misaligned();
        test_priority();
        test_stall();
        test_wrap_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
Program-counter and fetch-redirect unit for the RV32 core. It owns the PC register and drives instruction-fetch requests. It consumes the branch-resolution result from the execute stage (branch_taken), plus trap and mret requests, and selects the next PC. After every redirect it issues a timed flush to the IF/ID pipeline registers and reports misaligned control-transfer targets to the trap logic.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 2, number of cycles flush_o stays high after a redirect (1..7).

Ports:
clk_in  input  1  core clock, rising edge.
rst_n_in  input  1  asynchronous active-low reset.
ex_valid_in  input  1  execute-stage instruction is valid.
opcode_6_2_in  input  5  opcode[6:2] of the EX instruction.
branch_taken_in  input  1  conditional-branch outcome from the branch unit.
ex_pc_in  input  32  PC of the EX instruction.
imm_in  input  32  sign-extended immediate of the EX instruction.
rs1_in  input  32  rs1 operand, used for JALR.
trap_taken_in  input  1  trap request.
trap_vector_in  input  32  trap handler address.
mret_in  input  1  return-from-trap request.
epc_in  input  32  return address for mret.
stall_in  input  1  hold the PC (hazard stall).
imem_ready_in  input  1  instruction memory accepts the request.
imem_req_o  output  1  fetch request valid.
pc_o  output  32  current fetch address.
pc_plus4_o  output  32  pc_o + 4, combinational.
flush_o  output  1  kill the IF/ID pipeline registers.
misaligned_o  output  1  one-cycle pulse: misaligned target detected.
misaligned_addr_o  output  32  offending target address.

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - pc_o=RESET_VECTOR, state=BOOT.
  - imem_req_o=0, flush_o=0, misaligned_o=0, misaligned_addr_o=0, flush counter=0.
  - Reset asserted mid-flush or mid-redirect aborts the operation immediately.
- FSM states: BOOT, RUN, FLUSH.
  - BOOT: lasts exactly one cycle after reset deassertion, imem_req_o=0. Then goes to RUN.
  - RUN: imem_req_o=1.
  - FLUSH: imem_req_o=1, flush_o=1. Counter loads FLUSH_CYCLES-1 on entry and decrements each cycle. Returns to RUN when the counter is 0.
- Redirect sources, in priority order (evaluated in RUN and FLUSH; trap/mret also in BOOT):
  1. trap_taken_in: next PC = trap_vector_in.
  2. mret_in: next PC = epc_in.
  3. EX control transfer, only when ex_valid_in=1 and state=RUN. EX requests arriving during FLUSH are wrong-path and ignored.
     - opcode 11000 with branch_taken_in=1: target = ex_pc_in + imm_in.
     - opcode 11011 (JAL): target = ex_pc_in + imm_in, unconditional.
     - opcode 11001 (JALR): target = (rs1_in + imm_in) with bit0 cleared, unconditional.
- Misaligned target (EX source only):
  - Condition: target[1:0] != 0 after the JALR bit0 clear.
  - No redirect occurs. Next cycle misaligned_o=1 for exactly one cycle with misaligned_addr_o = target.
  - PC continues sequentially; the trap logic responds via trap_taken_in.
- Any accepted redirect:
  - pc_o = target on the next edge, independent of imem_ready_in and stall_in.
  - State goes to FLUSH, so flush_o rises the cycle after the redirect.
  - A trap or mret arriving during FLUSH redirects again and reloads the counter.
- Sequential advance:
  - pc_o += 4 when imem_req_o && imem_ready_in && !stall_in and no redirect is pending.
  - Otherwise pc_o holds.
- Arithmetic: all 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Simultaneous events: a redirect beats stall_in and imem_ready_in. Trap beats mret and EX in the same cycle; the lower-priority request is dropped, not queued.

Test Plan:
- Reset with RESET_VECTOR=32'h100, release, imem_ready_in=1 -> BOOT cycle with imem_req_o=0, then pc_o=0x100, 0x104, 0x108 on successive cycles.
- ex_valid=1, opcode 11000, branch_taken=1, ex_pc=0x200, imm=0x40 -> next cycle pc_o=0x240; flush_o high exactly 2 cycles; EX JAL injected during the flush is ignored.
- JALR with rs1=0x1003, imm=0x4 -> pc_o=0x1006 is misaligned, so no redirect; misaligned_o=1 for one cycle with misaligned_addr_o=0x1006; PC keeps incrementing.
- trap_taken=1 (vector 0x80), mret=1 and a taken branch in the same cycle -> pc_o=0x80; mret and branch are dropped.
- stall_in=1 for 3 cycles with imem_ready_in=1 -> pc_o frozen; a taken branch during the stall still redirects.
- pc_o=0xFFFF_FFFC, advance -> pc_o=0x0. Also assert rst_n_in low during FLUSH -> flush_o=0 and pc_o=RESET_VECTOR immediately, without waiting for a clock edge.
